// File: rtl/pit_pkg.sv
// Shared types, constants and helpers for the KR580VI53-style interval timer.
package pit_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_BOTH  = 2'b11
  } rw_t;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_PEND = 2'd1,
    RS_RUN  = 2'd2
  } run_state_t;

  localparam logic [1:0] A_CNT0 = 2'd0;
  localparam logic [1:0] A_CNT1 = 2'd1;
  localparam logic [1:0] A_CNT2 = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  // Unsupported 8253 modes collapse onto the nearest supported one.
  function automatic mode_t decode_mode(input logic [2:0] m);
    case (m)
      3'd2, 3'd6: decode_mode = MODE2;
      3'd3, 3'd7: decode_mode = MODE3;
      default:    decode_mode = MODE0;
    endcase
  endfunction

endpackage

// File: rtl/pit_counter.sv
// One 16-bit binary down-counter channel: count/output latch registers,
// read/write byte flip-flops, load/run sequencing and tout generation.
module pit_counter
  import pit_pkg::*;
#(
  parameter int unsigned TICK_SYNC = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       gate,
  input  logic       ctrl_wr,
  input  logic       data_wr,
  input  logic [7:0] data_in,
  input  logic       rd_adv,
  output logic [7:0] rd_data,
  output logic       tout
);

  mode_t       mode;
  rw_t         rw;
  rw_t         ctrl_rw;
  mode_t       ctrl_mode;
  run_state_t  state, state_nx;
  logic [15:0] cr, count, ol, half_hi, half_lo, rd_word;
  logic [16:0] n_full;
  logic        latched, wr_msb, rd_msb;
  logic        gate_eff, gate_prev, gate_rise;
  logic        load_now, count_en, wr_done;

  generate
    if (TICK_SYNC != 0) begin : g_sync
      logic gate_q;
      always_ff @(posedge clock) begin
        if (!reset_n) gate_q <= 1'b0;
        else          gate_q <= gate;
      end
      assign gate_eff = gate_q;
    end else begin : g_direct
      assign gate_eff = gate;
    end
  endgenerate

  assign ctrl_rw   = rw_t'(data_in[5:4]);
  assign ctrl_mode = decode_mode(data_in[3:1]);
  assign gate_rise = gate_eff & ~gate_prev & (mode != MODE0);
  assign wr_done   = data_wr & ((rw != RW_BOTH) | wr_msb);

  // A count register of zero stands for 65536; mode 3 splits N into ceil/floor halves.
  assign n_full  = (cr == 16'd0) ? 17'h10000 : {1'b0, cr};
  assign half_hi = 16'((n_full + 17'd1) >> 1);
  assign half_lo = (n_full[16:1] == 16'd0) ? 16'd1 : n_full[16:1];

  always_ff @(posedge clock) begin
    if (!reset_n) state <= RS_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (tick && state == RS_PEND)                 state_nx = RS_RUN;
    if (gate_rise && state == RS_RUN)             state_nx = RS_PEND;
    if (ctrl_wr && ctrl_rw != RW_LATCH)           state_nx = RS_IDLE;
    if (wr_done)                                  state_nx = RS_PEND;
  end

  always_comb begin
    load_now = 1'b0;
    count_en = 1'b0;
    if (tick) begin
      load_now = (state == RS_PEND);
      count_en = (state == RS_RUN) && gate_eff;
    end
  end

  // Tick effects use pre-write state; bus writes later in this block take priority.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode      <= MODE0;
      rw        <= RW_BOTH;
      cr        <= '0;
      count     <= '0;
      ol        <= '0;
      latched   <= 1'b0;
      wr_msb    <= 1'b0;
      rd_msb    <= 1'b0;
      tout      <= 1'b0;
      gate_prev <= 1'b0;
    end else begin
      gate_prev <= gate_eff;
      if (load_now) begin
        count <= (mode == MODE3) ? half_hi : cr;
        if (mode != MODE0) tout <= 1'b1;
      end else if (count_en) begin
        case (mode)
          MODE2: begin
            if (count == 16'd1) begin
              count <= cr;
              tout  <= 1'b1;
            end else begin
              count <= count - 16'd1;
              if (count == 16'd2) tout <= 1'b0;
            end
          end
          MODE3: begin
            if (count == 16'd1) begin
              tout  <= ~tout;
              count <= tout ? half_lo : half_hi;
            end else begin
              count <= count - 16'd1;
            end
          end
          default: begin
            count <= count - 16'd1;
            if (count == 16'd1) tout <= 1'b1;
          end
        endcase
      end
      if (mode != MODE0 && !gate_eff) tout <= 1'b1;

      if (ctrl_wr) begin
        if (ctrl_rw != RW_LATCH) begin
          mode    <= ctrl_mode;
          rw      <= ctrl_rw;
          wr_msb  <= 1'b0;
          rd_msb  <= 1'b0;
          latched <= 1'b0;
          tout    <= (ctrl_mode != MODE0);
        end else if (!latched) begin
          ol      <= count;
          latched <= 1'b1;
        end
      end

      if (data_wr) begin
        case (rw)
          RW_LSB: cr <= {8'h00, data_in};
          RW_MSB: cr <= {data_in, 8'h00};
          default: begin
            if (wr_msb) cr[15:8] <= data_in;
            else        cr[7:0]  <= data_in;
            wr_msb <= ~wr_msb;
          end
        endcase
        if (wr_done && mode == MODE0) tout <= 1'b0;
      end

      if (rd_adv) begin
        if (rw == RW_BOTH)           rd_msb  <= ~rd_msb;
        if (rw != RW_BOTH || rd_msb) latched <= 1'b0;
      end
    end
  end

  assign rd_word = latched ? ol : count;
  assign rd_data = (rw == RW_MSB || (rw == RW_BOTH && rd_msb)) ? rd_word[15:8] : rd_word[7:0];

endmodule

// File: rtl/pit_vi53_lite.sv
// Port-mapped three-channel interval timer: address decode, control-word
// dispatch to the counter channels and the read-data mux.
module pit_vi53_lite
  import pit_pkg::*;
#(
  parameter int unsigned TICK_SYNC = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       tick,
  input  logic       sel,
  input  logic [1:0] addr,
  input  logic       port_we,
  input  logic [7:0] data_in,
  input  logic       rd_stb,
  output logic [7:0] data_out,
  input  logic [2:0] gate,
  output logic [2:0] tout
);

  logic       wr_en, rd_en;
  logic [2:0] data_wr, ctrl_wr, rd_adv;
  logic [7:0] rd_data [3];

  assign wr_en = ce & sel & port_we;
  assign rd_en = ce & sel & rd_stb;

  // Select field 3 matches no channel, so such control words are dropped.
  always_comb begin
    data_wr = '0;
    ctrl_wr = '0;
    rd_adv  = '0;
    for (int i = 0; i < 3; i++) begin
      data_wr[i] = wr_en && (addr == 2'(i));
      ctrl_wr[i] = wr_en && (addr == A_CTRL) && (data_in[7:6] == 2'(i));
      rd_adv[i]  = rd_en && (addr == 2'(i));
    end
  end

  generate
    for (genvar g = 0; g < 3; g++) begin : g_cnt
      pit_counter #(.TICK_SYNC(TICK_SYNC)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick),
        .gate    (gate[g]),
        .ctrl_wr (ctrl_wr[g]),
        .data_wr (data_wr[g]),
        .data_in (data_in),
        .rd_adv  (rd_adv[g]),
        .rd_data (rd_data[g]),
        .tout    (tout[g])
      );
    end
  endgenerate

  always_comb begin
    data_out = 8'hFF;
    case (addr)
      A_CNT0:  data_out = rd_data[0];
      A_CNT1:  data_out = rd_data[1];
      A_CNT2:  data_out = rd_data[2];
      default: data_out = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_pit_vi53_lite.sv
// Randomized self-checking bench for pit_vi53_lite against a tick-index
// arithmetic model of modes 0, 2 and 3.
module tb_pit_vi53_lite;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       tick = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       port_we = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd_stb = 1'b0;
  logic [7:0] data_out;
  logic [2:0] gate = 3'b111;
  logic [2:0] tout;

  int total = 0;
  int bad   = 0;

  pit_vi53_lite dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ce       (ce),
    .tick     (tick),
    .sel      (sel),
    .addr     (addr),
    .port_we  (port_we),
    .data_in  (data_in),
    .rd_stb   (rd_stb),
    .data_out (data_out),
    .gate     (gate),
    .tout     (tout)
  );

  always #5 clock = ~clock;

  // Model: k = ticks since the load tick (load tick is k = 0), n = 1..65536.
  function automatic logic model_tout(input int m, input int n, input int k);
    if (m == 0)      return (k >= n);
    else if (m == 2) return ((k % n) != n - 1);
    else             return ((k % n) < (n + 1) / 2);
  endfunction

  function automatic logic [15:0] model_ce(input int m, input int n, input int k);
    int p, hi;
    if (m == 0) return 16'((n - k) & 32'hFFFF);
    if (m == 2) return 16'((n - (k % n)) & 32'hFFFF);
    p  = k % n;
    hi = (n + 1) / 2;
    return (p < hi) ? 16'(hi - p) : 16'(n - p);
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic with_tick);
    ce = 1'b1; sel = 1'b1; port_we = 1'b1; addr = a; data_in = d; tick = with_tick;
    cyc();
    ce = 1'b0; sel = 1'b0; port_we = 1'b0; tick = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    ce = 1'b1; sel = 1'b1; addr = a; rd_stb = 1'b1;
    #1;
    d = data_out;
    cyc();
    ce = 1'b0; sel = 1'b0; rd_stb = 1'b0;
  endtask

  task automatic read_ce(input int c, output logic [15:0] v);
    logic [7:0] lo, hi;
    bus_read(2'(c), lo);
    bus_read(2'(c), hi);
    v = {hi, lo};
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic load_count(input int c, input int n);
    bus_write(2'(c), 8'(n), 1'b0);
    bus_write(2'(c), 8'(n >> 8), 1'b0);
  endtask

  task automatic test_reset();
    logic [7:0]  d;
    logic [15:0] v;
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    total++;
    if (tout !== 3'b000) begin bad++; $display("[TB] FAIL reset_tout: got %b want 000", tout); end
    for (int c = 0; c < 3; c++) begin
      read_ce(c, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("[TB] FAIL reset_ce%0d: got %h want 0000", c, v); end
    end
    bus_read(2'd3, d);
    total++;
    if (d !== 8'hFF) begin bad++; $display("[TB] FAIL ctrl_read: got %h want ff", d); end
  endtask

  task automatic test_mode0();
    logic [2:0]  codes [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic [15:0] v;
    int c, n;
    for (int r = 0; r < 3; r++) begin
      c = (r == 0) ? 0 : $urandom_range(0, 2);
      n = (r == 0) ? 5 : $urandom_range(2, 30);
      bus_write(2'd3, {2'(c), 2'b11, codes[(r == 0) ? 0 : $urandom_range(0, 3)], 1'b0}, 1'b0);
      total++;
      if (tout[c] !== 1'b0) begin bad++; $display("[TB] FAIL m0_ctrl_tout%0d: got %b want 0", c, tout[c]); end
      load_count(c, n);
      for (int j = 1; j <= n + 11; j++) begin
        do_tick();
        total++;
        if (tout[c] !== model_tout(0, n, j - 1)) begin
          bad++; $display("[TB] FAIL m0_tout c%0d n%0d tick%0d: got %b want %b", c, n, j, tout[c], model_tout(0, n, j - 1));
        end
      end
      read_ce(c, v);
      total++;
      if (v !== model_ce(0, n, n + 10)) begin
        bad++; $display("[TB] FAIL m0_ce c%0d: got %h want %h", c, v, model_ce(0, n, n + 10));
      end
    end
  endtask

  task automatic test_mode2();
    logic [15:0] v, v0;
    int c, n, kl;
    for (int r = 0; r < 2; r++) begin
      c = (r == 0) ? 1 : $urandom_range(0, 2);
      n = (r == 0) ? 4 : $urandom_range(3, 25);
      bus_write(2'd3, {2'(c), 2'b11, ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b010, 1'b0}, 1'b0);
      load_count(c, n);
      kl = 0;
      for (int j = 1; j <= 3 * n; j++) begin
        do_tick();
        kl = j - 1;
        total++;
        if (tout[c] !== model_tout(2, n, kl)) begin
          bad++; $display("[TB] FAIL m2_tout c%0d n%0d tick%0d: got %b want %b", c, n, j, tout[c], model_tout(2, n, kl));
        end
      end
      read_ce(c, v);
      total++;
      if (v !== model_ce(2, n, kl)) begin bad++; $display("[TB] FAIL m2_ce c%0d: got %h want %h", c, v, model_ce(2, n, kl)); end
      if (r == 1) begin
        do_tick();
        kl++;
        gate[c] = 1'b0;
        repeat (3) cyc();
        total++;
        if (tout[c] !== 1'b1) begin bad++; $display("[TB] FAIL m2_gate_low_tout: got %b want 1", tout[c]); end
        read_ce(c, v0);
        repeat (4) do_tick();
        read_ce(c, v);
        total++;
        if (v !== model_ce(2, n, kl)) begin bad++; $display("[TB] FAIL m2_gate_hold: got %h want %h", v, model_ce(2, n, kl)); end
        gate[c] = 1'b1;
        repeat (3) cyc();
        for (int j = 1; j <= n + 2; j++) begin
          do_tick();
          total++;
          if (tout[c] !== model_tout(2, n, j - 1)) begin
            bad++; $display("[TB] FAIL m2_gate_restart tick%0d: got %b want %b", j, tout[c], model_tout(2, n, j - 1));
          end
        end
        read_ce(c, v);
        total++;
        if (v !== model_ce(2, n, n + 1)) begin bad++; $display("[TB] FAIL m2_restart_ce: got %h want %h", v, model_ce(2, n, n + 1)); end
      end
    end
  endtask

  task automatic test_mode3();
    logic [15:0] v;
    int c, n, kl;
    for (int r = 0; r < 3; r++) begin
      c = (r < 2) ? 2 : $urandom_range(0, 2);
      n = (r == 0) ? 5 : (r == 1) ? 4 : $urandom_range(2, 25);
      bus_write(2'd3, {2'(c), 2'b11, ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b011, 1'b0}, 1'b0);
      load_count(c, n);
      kl = 0;
      for (int j = 1; j <= 3 * n; j++) begin
        do_tick();
        kl = j - 1;
        total++;
        if (tout[c] !== model_tout(3, n, kl)) begin
          bad++; $display("[TB] FAIL m3_tout c%0d n%0d tick%0d: got %b want %b", c, n, j, tout[c], model_tout(3, n, kl));
        end
      end
      read_ce(c, v);
      total++;
      if (v !== model_ce(3, n, kl)) begin bad++; $display("[TB] FAIL m3_ce c%0d n%0d: got %h want %h", c, n, v, model_ce(3, n, kl)); end
    end
  endtask

  task automatic test_latch();
    logic [7:0]  lo, hi;
    logic [15:0] ol;
    int t;
    bus_write(2'd3, 8'h30, 1'b0);
    load_count(0, 16'h1234);
    t = $urandom_range(1, 5);
    repeat (t) do_tick();
    ol = model_ce(0, 16'h1234, t - 1);
    bus_write(2'd3, 8'h00, 1'b0);
    repeat (3) do_tick();
    bus_write(2'd3, 8'h00, 1'b0);
    do_tick();
    bus_read(2'd0, lo);
    do_tick();
    bus_read(2'd0, hi);
    total++;
    if ({hi, lo} !== ol) begin bad++; $display("[TB] FAIL latch_value: got %h want %h", {hi, lo}, ol); end
    bus_read(2'd0, lo);
    bus_read(2'd0, hi);
    total++;
    if ({hi, lo} !== model_ce(0, 16'h1234, t + 4)) begin
      bad++; $display("[TB] FAIL latch_live: got %h want %h", {hi, lo}, model_ce(0, 16'h1234, t + 4));
    end
  endtask

  task automatic test_edges();
    logic [15:0] v;
    int n, j;
    bus_write(2'd3, 8'h74, 1'b0);
    load_count(1, 0);
    do_tick();
    read_ce(1, v);
    total++;
    if (v !== model_ce(2, 65536, 0)) begin bad++; $display("[TB] FAIL zero_load: got %h want %h", v, model_ce(2, 65536, 0)); end
    do_tick();
    read_ce(1, v);
    total++;
    if (v !== model_ce(2, 65536, 1) || tout[1] !== 1'b1) begin
      bad++; $display("[TB] FAIL zero_wrap: got %h/%b want %h/1", v, tout[1], model_ce(2, 65536, 1));
    end

    n = $urandom_range(20, 40);
    bus_write(2'd3, 8'h30, 1'b0);
    load_count(0, n);
    j = $urandom_range(2, 10);
    repeat (j) do_tick();
    bus_write(2'd3, 8'h34, 1'b0);
    total++;
    if (tout[0] !== 1'b1) begin bad++; $display("[TB] FAIL ctrl_stop_tout: got %b want 1", tout[0]); end
    repeat (3) do_tick();
    read_ce(0, v);
    total++;
    if (v !== model_ce(0, n, j - 1)) begin bad++; $display("[TB] FAIL ctrl_stop_ce: got %h want %h", v, model_ce(0, n, j - 1)); end

    bus_write(2'd3, 8'hB6, 1'b0);
    load_count(2, $urandom_range(6, 30));
    repeat (3) do_tick();
    reset_n = 1'b0;
    bus_write(2'd2, 8'h55, 1'b1);
    reset_n = 1'b1;
    total++;
    if (tout !== 3'b000) begin bad++; $display("[TB] FAIL midreset_tout: got %b want 000", tout); end
    do_tick();
    read_ce(2, v);
    total++;
    if (v !== 16'h0000) begin bad++; $display("[TB] FAIL midreset_ce: got %h want 0000", v); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] v;
    logic [2:0]  t0;
    int n1, n2, t;
    n1 = $urandom_range(6, 20);
    n2 = $urandom_range(3, 1000);
    bus_write(2'd3, 8'h74, 1'b0);
    load_count(1, n1);
    t = $urandom_range(2, 2 * n1);
    repeat (t) do_tick();
    bus_write(2'd1, 8'(n2), 1'b0);
    bus_write(2'd1, 8'(n2 >> 8), 1'b1);
    total++;
    if (tout[1] !== model_tout(2, n1, t)) begin bad++; $display("[TB] FAIL simul_tout: got %b want %b", tout[1], model_tout(2, n1, t)); end
    read_ce(1, v);
    total++;
    if (v !== model_ce(2, n1, t)) begin bad++; $display("[TB] FAIL simul_no_load: got %h want %h", v, model_ce(2, n1, t)); end
    do_tick();
    read_ce(1, v);
    total++;
    if (v !== model_ce(2, n2, 0)) begin bad++; $display("[TB] FAIL simul_next_load: got %h want %h", v, model_ce(2, n2, 0)); end

    t0 = tout;
    bus_write(2'd3, {2'b11, 6'($urandom_range(16, 63))}, 1'b0);
    total++;
    if (tout !== t0) begin bad++; $display("[TB] FAIL sc3_tout: got %b want %b", tout, t0); end
    read_ce(1, v);
    total++;
    if (v !== model_ce(2, n2, 0)) begin bad++; $display("[TB] FAIL sc3_ce: got %h want %h", v, model_ce(2, n2, 0)); end
    do_tick();
    read_ce(1, v);
    total++;
    if (v !== model_ce(2, n2, 1)) begin bad++; $display("[TB] FAIL sc3_mode_kept: got %h want %h", v, model_ce(2, n2, 1)); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode2();
    test_mode3();
    test_latch();
    test_edges();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
